// File: rtl/vga_ball.sv
// vga_ball: 640x480 monochrome VGA scan-out from a 32K x 32 framebuffer with a write-only bus port.
// Timing runs at 50 MHz with each pixel held for two clocks; all video outputs trail the counters by 2 clocks.
module vga_ball (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] writedata,
   input  logic        write,
   input  logic        chipselect,
   input  logic [14:0] address,
   output logic [7:0]  VGA_R,
   output logic [7:0]  VGA_G,
   output logic [7:0]  VGA_B,
   output logic        VGA_CLK,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        VGA_BLANK_n,
   output logic        VGA_SYNC_n
);
   logic [10:0] r_hcount;
   logic [9:0]  r_vcount;
   logic [31:0] r_mem [32768];
   logic [31:0] r_word;
   logic [4:0]  r_bit;
   logic        r_hs, r_vs, r_blank_n;
   logic        w_hend, w_vend, w_blank_n, w_hs, w_vs, w_pix;
   logic [9:0]  w_col;
   logic [14:0] w_rd_addr;

   assign w_hend    = r_hcount == 11'd1599;
   assign w_vend    = r_vcount == 10'd524;
   assign w_col     = r_hcount[10:1];
   assign w_rd_addr = {r_vcount, w_col[9:5]};
   assign w_blank_n = r_hcount < 11'd1280 && r_vcount < 10'd480;
   assign w_hs      = !(r_hcount >= 11'd1312 && r_hcount <= 11'd1503);
   assign w_vs      = !(r_vcount >= 10'd490 && r_vcount <= 10'd491);
   // ~col[4:0] == 31 - col[4:0]: word MSB is the leftmost pixel
   assign w_pix     = r_word[~r_bit];
   assign VGA_CLK   = r_hcount[0];
   assign VGA_SYNC_n = 1'b0;

   always_ff @(posedge clk)
      if (reset) begin
         r_hcount <= 11'd0;
         r_vcount <= 10'd0;
      end else begin
         r_hcount <= w_hend ? 11'd0 : r_hcount + 11'd1;
         if (w_hend) r_vcount <= w_vend ? 10'd0 : r_vcount + 10'd1;
      end

   always_ff @(posedge clk) begin
      if (chipselect && write && !reset) r_mem[address] <= writedata;
      r_word <= r_mem[w_rd_addr];
   end

   // stage 1 carries sync/blank alongside the RAM read; stage 2 forms the colour
   always_ff @(posedge clk)
      if (reset) begin
         r_bit       <= 5'd0;
         r_hs        <= 1'b1;
         r_vs        <= 1'b1;
         r_blank_n   <= 1'b0;
         VGA_R       <= 8'h00;
         VGA_G       <= 8'h00;
         VGA_B       <= 8'h00;
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_n <= 1'b0;
      end else begin
         r_bit       <= w_col[4:0];
         r_hs        <= w_hs;
         r_vs        <= w_vs;
         r_blank_n   <= w_blank_n;
         VGA_R       <= (w_pix && r_blank_n) ? 8'hFF : 8'h00;
         VGA_G       <= (w_pix && r_blank_n) ? 8'hFF : 8'h00;
         VGA_B       <= (w_pix && r_blank_n) ? 8'hFF : 8'h00;
         VGA_HS      <= r_hs;
         VGA_VS      <= r_vs;
         VGA_BLANK_n <= r_blank_n;
      end
endmodule

// File: tb/tb_vga_ball.sv
// tb_vga_ball: scoreboard of expected video per clock plus directed fill/clear/mapping/timing/reset checks.
module tb_vga_ball;
   logic        clk = 1'b0;
   logic        reset, write, chipselect;
   logic [31:0] writedata;
   logic [14:0] address;
   logic [7:0]  VGA_R, VGA_G, VGA_B;
   logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n;

   vga_ball dut (
      .clk(clk), .reset(reset), .writedata(writedata), .write(write),
      .chipselect(chipselect), .address(address), .VGA_R(VGA_R), .VGA_G(VGA_G),
      .VGA_B(VGA_B), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
      .VGA_BLANK_n(VGA_BLANK_n), .VGA_SYNC_n(VGA_SYNC_n)
   );

   always #10 clk = ~clk;

   typedef struct { logic [23:0] rgb; logic hs, vs, bl, known; } exp_t;
   exp_t        q[$];
   exp_t        ce;
   logic [31:0] mm [int];
   int          mh = 0, mv = 0, tests = 0, fails = 0;
   bit          armed = 0, r1 = 0;
   int          wpos[$];

   function automatic exp_t model(input int h, input int v);
      exp_t e;
      int col, a;
      logic [31:0] w;
      col = h / 2;
      a = v * 32 + col / 32;
      e.bl = h < 1280 && v < 480;
      e.hs = !(h >= 1312 && h <= 1503);
      e.vs = !(v >= 490 && v <= 491);
      e.known = !e.bl || mm.exists(a);
      w = mm.exists(a) ? mm[a] : 32'h0;
      e.rgb = (e.bl && w[31 - col % 32]) ? 24'hFFFFFF : 24'h0;
      return e;
   endfunction

   // model state after each edge; outputs after edge n reflect the state after edge n-2
   always @(posedge clk) begin
      #1;
      if (reset) begin
         mh = 0;
         mv = 0;
         armed = 1;
      end else if (armed) begin
         if (chipselect && write) mm[int'(address)] = writedata;
         if (mh == 1599) begin
            mh = 0;
            mv = (mv == 524) ? 0 : mv + 1;
         end else mh++;
      end
      if (armed) begin
         q.push_back(model(mh, mv));
         ce = (reset || r1) ? '{24'h0, 1'b1, 1'b1, 1'b0, 1'b1} : q[0];
         if (q.size() > 2) void'(q.pop_front());
         tests++;
         assert (VGA_HS === ce.hs) else begin fails++; $error("FAIL sb_hs at h=%0d v=%0d got %b exp %b", mh, mv, VGA_HS, ce.hs); end
         tests++;
         assert (VGA_VS === ce.vs) else begin fails++; $error("FAIL sb_vs at h=%0d v=%0d got %b exp %b", mh, mv, VGA_VS, ce.vs); end
         tests++;
         assert (VGA_BLANK_n === ce.bl) else begin fails++; $error("FAIL sb_blank at h=%0d v=%0d got %b exp %b", mh, mv, VGA_BLANK_n, ce.bl); end
         if (ce.known) begin
            tests++;
            assert ({VGA_R, VGA_G, VGA_B} === ce.rgb) else begin fails++; $error("FAIL sb_rgb at h=%0d v=%0d got %h exp %h", mh, mv, {VGA_R, VGA_G, VGA_B}, ce.rgb); end
         end
      end
      r1 = reset;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin fails++; $error("FAIL %s got %0h exp %0h", tag, got, exp); end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) @(negedge clk);
      reset = 1'b0;
   endtask

   // k counts negedges after reset release; state after posedge k is hcount=k while k<1600
   task automatic count_white(input int len);
      wpos.delete();
      for (int k = 1; k <= len; k++) begin
         @(negedge clk);
         if (VGA_R === 8'hFF) wpos.push_back(k);
      end
   endtask

   function automatic int wp(input int i);
      return (wpos.size() > i) ? wpos[i] : -1;
   endfunction

   int t, lo, per, hi, late;

   initial begin
      reset = 1'b1; write = 1'b0; chipselect = 1'b0; address = '0; writedata = '0;
      repeat (5) @(negedge clk);
      chk("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h0);
      chk("rst_hs", 32'(VGA_HS), 32'd1);
      chk("rst_vs", 32'(VGA_VS), 32'd1);
      chk("rst_blank", 32'(VGA_BLANK_n), 32'd0);
      chk("sync_n", 32'(VGA_SYNC_n), 32'd0);
      reset = 1'b0;
      chipselect = 1'b1;
      for (int a = 0; a < 2048; a++) begin
         write = 1'b1; address = a[14:0]; writedata = 32'hFFFFFFFF;
         @(negedge clk);
         write = 1'b0;
         @(negedge clk);
      end
      chipselect = 1'b0;
      do_reset(3);
      count_white(1600);
      chk("fill_count", 32'(wpos.size()), 32'd1280);
      chk("fill_first", 32'(wp(0)), 32'd2);
      chk("vga_clk_even", 32'(VGA_CLK), 32'd0);
      @(negedge clk);
      chk("vga_clk_odd", 32'(VGA_CLK), 32'd1);
      t = 0;
      while (VGA_HS !== 1'b0 && t < 4000) begin @(negedge clk); t++; end
      chk("hs_fall_seen", 32'(t < 4000), 32'd1);
      lo = 0;
      while (VGA_HS === 1'b0 && lo < 4000) begin @(negedge clk); lo++; end
      chk("hs_low_width", 32'(lo), 32'd192);
      per = lo;
      while (VGA_HS === 1'b1 && per < 4000) begin @(negedge clk); per++; end
      chk("hs_period", 32'(per), 32'd1600);
      t = 0;
      while (VGA_BLANK_n !== 1'b1 && t < 4000) begin @(negedge clk); t++; end
      hi = 0;
      while (VGA_BLANK_n === 1'b1 && hi < 4000) begin @(negedge clk); hi++; end
      chk("blank_active_width", 32'(hi), 32'd1280);
      chipselect = 1'b1; write = 1'b1;
      for (int a = 0; a < 2048; a++) begin
         address = a[14:0]; writedata = 32'h0;
         @(negedge clk);
      end
      address = 15'h0000; writedata = 32'h80000000;
      @(negedge clk);
      address = 15'h0033; writedata = 32'h00000001;
      @(negedge clk);
      write = 1'b0; chipselect = 1'b0;
      do_reset(3);
      count_white(3300);
      chk("map_count", 32'(wpos.size()), 32'd4);
      chk("map_px0_a", 32'(wp(0)), 32'd2);
      chk("map_px0_b", 32'(wp(1)), 32'd3);
      chk("map_px639_a", 32'(wp(2)), 32'd2880);
      chk("map_px639_b", 32'(wp(3)), 32'd2881);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h0);
      chk("midrst_hs", 32'(VGA_HS), 32'd1);
      chk("midrst_vs", 32'(VGA_VS), 32'd1);
      chk("midrst_blank", 32'(VGA_BLANK_n), 32'd0);
      chk("midrst_vga_clk", 32'(VGA_CLK), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chipselect = 1'b1; write = 1'b1;
      address = 15'h0040; writedata = 32'hA5A5A5A5; @(negedge clk);
      address = 15'h0045; writedata = 32'h0000FFFF; @(negedge clk);
      address = 15'h004A; writedata = 32'h80000001; @(negedge clk);
      address = 15'h0053; writedata = 32'hFFFFFFFF; @(negedge clk);
      address = 15'h0060; writedata = 32'hFFFFFFFF;
      do_reset(3);
      write = 1'b0; chipselect = 1'b0;
      count_white(5000);
      chk("b2b_count", 32'(wpos.size()), 32'd136);
      chk("map_kept_px0", 32'(wp(0)), 32'd2);
      late = 0;
      foreach (wpos[i]) if (wpos[i] >= 4800) late++;
      chk("rst_write_ignored", 32'(late), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
